// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 VGA timing constants, the 320x240 source
// frame geometry and the {y, x} frame-buffer address layout. Used by the
// frame reader, the enhanced filter and the capture side.
//
// Contents:
//   H_* / V_* timing defaults, H_TOTAL / V_TOTAL line and frame totals
//   SRC_W / SRC_H source image size, X_* / Y_* address field positions
//   pix_ctrl_t  per-pixel control word carried through latency pipelines
//   pack_addr() builds a frame-buffer address from x and y
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int SRC_W = 320;
  localparam int SRC_H = 240;

  localparam int X_LSB  = 0;
  localparam int X_W    = $clog2(SRC_W);
  localparam int Y_LSB  = X_LSB + X_W;
  localparam int Y_W    = $clog2(SRC_H);
  localparam int ADDR_W = X_W + Y_W;
  localparam int PIX_W  = 12;

  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);

  // Everything derived from the raster counters that has to travel in
  // lock-step with the frame-buffer read.
  typedef struct packed {
    logic              active;
    logic              hsync;
    logic              vsync;
    logic              frame;
    logic              en;
    logic [ADDR_W-1:0] addr;
  } pix_ctrl_t;

  // Blanking with both syncs deasserted (high).
  localparam pix_ctrl_t PIX_CTRL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                          frame: 1'b0, en: 1'b0, addr: '0};

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[X_LSB +: X_W] = x;
    a[Y_LSB +: Y_W] = y;
    return a;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running horizontal/vertical raster counters with
// active-area, sync and first-pixel decode. The decode is combinational from
// the counter registers; any latency matching is done by the user.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high; counters return to (0,0)
//   active       raster position is inside the visible area
//   hsync/vsync  active-low sync pulses
//   frame_first  raster position is (0,0)
//   x / y        source-image coordinates (each source pixel covers 2x2)
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   active,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_first,
  output logic [vga_pkg::X_W-1:0] x,
  output logic [vga_pkg::Y_W-1:0] y
);
  import vga_pkg::*;

  localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;

  // Raster counters: the line counter advances only when the pixel counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + H_CNT_W'(1);
    end
  end

  // Position decode; dropping the counter LSBs doubles each source pixel.
  always_comb begin
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vsync       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    x           = h_cnt[X_W:1];
    y           = v_cnt[Y_W:1];
  end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: drives 640x480@60 VGA timing, reads the 320x240 RGB444
// frame buffer with 2x2 pixel replication and delivers pixel, address and
// syncs phase-aligned, RD_LATENCY+2 cycles after the raster counters.
//
// Ports:
//   clk, reset    pixel clock, synchronous active-high reset
//   enable        0 blanks pixel_out to black; timing keeps running
//   rd_addr       frame-buffer read address {y, x}, held during blanking
//   rd_data       frame-buffer data, valid RD_LATENCY cycles after rd_addr
//   pixel_out     aligned pixel (black outside the active area or when disabled)
//   pixel_addr    address that produced pixel_out, held while not valid
//   pixel_valid   pixel_out is in the active area
//   hsync, vsync  active-low syncs
//   frame_start   one-cycle pulse with pixel (0,0)
module vga_frame_reader #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic [vga_pkg::ADDR_W-1:0] rd_addr,
  input  logic [vga_pkg::PIX_W-1:0]  rd_data,
  output logic [vga_pkg::PIX_W-1:0]  pixel_out,
  output logic [vga_pkg::ADDR_W-1:0] pixel_addr,
  output logic                      pixel_valid,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      frame_start
);
  import vga_pkg::*;

  // One stage lines up with the rd_addr register, RD_LATENCY more with the
  // memory; the output register then captures rd_data and control together.
  localparam int DEPTH = RD_LATENCY + 1;

  logic              tg_active;
  logic              tg_hsync;
  logic              tg_vsync;
  logic              tg_frame;
  logic [X_W-1:0]    tg_x;
  logic [Y_W-1:0]    tg_y;
  logic [ADDR_W-1:0] tg_addr;
  pix_ctrl_t         pipe [DEPTH];
  pix_ctrl_t         tail;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .active      (tg_active),
    .hsync       (tg_hsync),
    .vsync       (tg_vsync),
    .frame_first (tg_frame),
    .x           (tg_x),
    .y           (tg_y)
  );

  assign tg_addr = pack_addr(tg_x, tg_y);
  assign tail    = pipe[DEPTH-1];

  // Read address plus the latency-matching shift register. rd_addr only
  // follows active positions so blanking never reads past 319/239.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= PIX_CTRL_IDLE;
      end
    end else begin
      if (tg_active) begin
        rd_addr <= tg_addr;
      end
      pipe[0] <= '{active: tg_active, hsync: tg_hsync, vsync: tg_vsync,
                   frame: tg_frame, en: enable, addr: tg_addr};
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Output register: rd_data and its delayed control leave on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out   <= '0;
      pixel_addr  <= '0;
      pixel_valid <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel_out   <= (tail.active && tail.en) ? rd_data : '0;
      pixel_valid <= tail.active;
      hsync       <= tail.hsync;
      vsync       <= tail.vsync;
      frame_start <= tail.frame;
      if (tail.active) begin
        pixel_addr <= tail.addr;
      end
    end
  end

endmodule
